crtc_gen: RTL and testbench

Parametrised CRT timing generator for the DVI output path: counts pixels and lines from a programmable blanking/active geometry and drives registered hsync/vsync/data-enable, active and raw coordinates, line/frame strobes and a frame counter to the pixel pipeline. It runs entirely in the pixel clock domain. Timing registers are written by the control block and can be applied atomically at frame boundaries.

---
 rtl/crtc_gen.sv | 170 +++++++++++++++++
 tb/tb_crtc_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_gen.sv
// crtc_gen: CRT timing generator for the DVI output path (pixel clock domain).
// Counts raw pixels/lines over a front porch, sync, back porch, active layout.
// Outputs are registered decodes of the previous cycle's counter state.
// Optional feature macro: CRTC_GEN_SHADOW_EN. When it is defined, the timing
// inputs pass through shadow registers that load at end of frame after a
// cfg_update_i request. When it is not defined, the timing inputs are used
// live every cycle.
module crtc_gen #(
    parameter int unsigned W         = 12,
    parameter int unsigned FCNT_W    = 8,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic [W-1:0]      ha_i,
    input  logic [W-1:0]      hfp_i,
    input  logic [W-1:0]      hsw_i,
    input  logic [W-1:0]      hbp_i,
    input  logic [W-1:0]      va_i,
    input  logic [W-1:0]      vfp_i,
    input  logic [W-1:0]      vsw_i,
    input  logic [W-1:0]      vbp_i,
    input  logic              cfg_update_i,
    output logic              cfg_ack_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic              hblank_o,
    output logic              vblank_o,
    output logic [W-1:0]      x_o,
    output logic [W-1:0]      y_o,
    output logic [W-1:0]      raw_x_o,
    output logic [W-1:0]      raw_y_o,
    output logic              line_start_o,
    output logic              frame_start_o,
    output logic [FCNT_W-1:0] frame_cnt_o
);

    // geometry in effect this cycle
    logic [W-1:0] ha, hfp, hsw, hbp, va, vfp, vsw, vbp;

    logic [W-1:0]      rx_q, rx_d, ry_q, ry_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // sums carry one extra bit so HT/VT = 2^W is representable
    logic [W:0] hbl, ht, hs_end, vbl, vt, vs_end, rx1, ry1;
    logic       h_wrap, v_wrap, eof;

    assign hbl    = {1'b0, hfp} + {1'b0, hsw} + {1'b0, hbp};
    assign ht     = hbl + {1'b0, ha};
    assign hs_end = {1'b0, hfp} + {1'b0, hsw};
    assign vbl    = {1'b0, vfp} + {1'b0, vsw} + {1'b0, vbp};
    assign vt     = vbl + {1'b0, va};
    assign vs_end = {1'b0, vfp} + {1'b0, vsw};
    assign rx1    = {1'b0, rx_q} + 1'b1;
    assign ry1    = {1'b0, ry_q} + 1'b1;
    // >= so a counter left beyond a shrunken total still wraps
    assign h_wrap = (rx1 >= ht);
    assign v_wrap = (ry1 >= vt);
    assign eof    = enable_i & h_wrap & v_wrap;

`ifdef CRTC_GEN_SHADOW_EN
    logic [W-1:0] ha_q, hfp_q, hsw_q, hbp_q, va_q, vfp_q, vsw_q, vbp_q;
    logic         pend_q, pend_d, ack_q, apply;

    // a request in the apply cycle itself is folded in; disabled applies at once
    assign apply  = (pend_q | cfg_update_i) & (eof | ~enable_i);
    assign pend_d = (pend_q | cfg_update_i) & ~apply;

    // shadow geometry, pending request and ack pulse
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            {ha_q, hfp_q, hsw_q, hbp_q} <= '0;
            {va_q, vfp_q, vsw_q, vbp_q} <= '0;
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            if (apply) begin
                {ha_q, hfp_q, hsw_q, hbp_q} <= {ha_i, hfp_i, hsw_i, hbp_i};
                {va_q, vfp_q, vsw_q, vbp_q} <= {va_i, vfp_i, vsw_i, vbp_i};
            end
            pend_q <= pend_d;
            ack_q  <= apply;
        end
    end

    assign {ha, hfp, hsw, hbp} = {ha_q, hfp_q, hsw_q, hbp_q};
    assign {va, vfp, vsw, vbp} = {va_q, vfp_q, vsw_q, vbp_q};
    assign cfg_ack_o = ack_q;
`else
    logic unused_cfg_update;
    assign unused_cfg_update   = cfg_update_i;
    assign {ha, hfp, hsw, hbp} = {ha_i, hfp_i, hsw_i, hbp_i};
    assign {va, vfp, vsw, vbp} = {va_i, vfp_i, vsw_i, vbp_i};
    assign cfg_ack_o = 1'b0;
`endif

    // raw pixel/line counters and frame counter next state
    always_comb begin
        rx_d   = rx_q;
        ry_d   = ry_q;
        fcnt_d = fcnt_q;
        if (!enable_i) begin
            rx_d = '0;
            ry_d = '0;
        end else if (h_wrap) begin
            rx_d = '0;
            if (v_wrap) begin
                ry_d   = '0;
                fcnt_d = fcnt_q + FCNT_W'(1);
            end else begin
                ry_d = ry_q + W'(1);
            end
        end else begin
            rx_d = rx_q + W'(1);
        end
    end

    // counter state registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_q   <= '0;
            ry_q   <= '0;
            fcnt_q <= '0;
        end else begin
            rx_q   <= rx_d;
            ry_q   <= ry_d;
            fcnt_q <= fcnt_d;
        end
    end

    logic hb, vb, de;
    assign hb = ({1'b0, rx_q} < hbl);
    assign vb = ({1'b0, ry_q} < vbl);
    assign de = ~hb & ~vb;

    // registered decode of this cycle's counter state; idle when disabled
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !enable_i) begin
            hsync_o       <= ~HSYNC_POL;
            vsync_o       <= ~VSYNC_POL;
            de_o          <= 1'b0;
            hblank_o      <= 1'b0;
            vblank_o      <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            raw_x_o       <= '0;
            raw_y_o       <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            hsync_o       <= (rx_q >= hfp && {1'b0, rx_q} < hs_end) ? HSYNC_POL : ~HSYNC_POL;
            vsync_o       <= (ry_q >= vfp && {1'b0, ry_q} < vs_end) ? VSYNC_POL : ~VSYNC_POL;
            de_o          <= de;
            hblank_o      <= hb;
            vblank_o      <= vb;
            x_o           <= de ? rx_q - hbl[W-1:0] : '0;
            y_o           <= de ? ry_q - vbl[W-1:0] : '0;
            raw_x_o       <= rx_q;
            raw_y_o       <= ry_q;
            line_start_o  <= (rx_q == '0);
            frame_start_o <= (rx_q == '0) && (ry_q == '0);
        end
    end

    assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_crtc_gen.sv
// Directed bench for crtc_gen: small 8x6 geometry, frame counter wrap at
// FCNT_W=2, enable gating, then live shrink or shadow update depending on
// CRTC_GEN_SHADOW_EN.
module tb_crtc_gen;
    localparam int W  = 12;
    localparam int FW = 2;
`ifdef CRTC_GEN_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, enable, cfg_update;
    logic [W-1:0]  ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    logic          cfg_ack_o, hsync_o, vsync_o, de_o, hblank_o, vblank_o;
    logic [W-1:0]  x_o, y_o, raw_x_o, raw_y_o;
    logic          line_start_o, frame_start_o;
    logic [FW-1:0] frame_cnt_o;

    crtc_gen #(.W(W), .FCNT_W(FW), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
        .ha_i(ha), .hfp_i(hfp), .hsw_i(hsw), .hbp_i(hbp),
        .va_i(va), .vfp_i(vfp), .vsw_i(vsw), .vbp_i(vbp),
        .cfg_update_i(cfg_update), .cfg_ack_o(cfg_ack_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .hblank_o(hblank_o), .vblank_o(vblank_o),
        .x_o(x_o), .y_o(y_o), .raw_x_o(raw_x_o), .raw_y_o(raw_y_o),
        .line_start_o(line_start_o), .frame_start_o(frame_start_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cfg_ack_o) ack_cnt++;
    endtask

    function automatic logic idle_ok();
        return !de_o && !hblank_o && !vblank_o && !line_start_o && !frame_start_o &&
               raw_x_o == '0 && raw_y_o == '0 && x_o == '0 && y_o == '0 &&
               hsync_o && vsync_o;
    endfunction

    initial begin
        logic [7:0]    hs_m, vs_m, de_xm, de_ym;
        int            de_n, hb_n, vb_n, ls_n, fs_n, fs_i0, xsum, ysum, xbad, bad, mx, dn;
        logic          found;
        logic [FW-1:0] fexp [5];
        fexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n = 1'b0; enable = 1'b1; cfg_update = 1'b0;
        ha = 12'd4; hfp = 12'd1; hsw = 12'd2; hbp = 12'd1;
        va = 12'd3; vfp = 12'd1; vsw = 12'd1; vbp = 12'd1;
        repeat (3) step();
        chk("rst_raw_x", 32'(raw_x_o), 0);
        chk("rst_raw_y", 32'(raw_y_o), 0);
        chk("rst_de", 32'(de_o), 0);
        chk("rst_fcnt", 32'(frame_cnt_o), 0);
        chk("rst_hsync", 32'(hsync_o), 1);
        chk("rst_vsync", 32'(vsync_o), 1);
        chk("rst_fstart", 32'(frame_start_o), 0);

        // one disabled cycle with an update request: loads shadows if present
        rst_n = 1'b1; enable = 1'b0; cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        chk("load_ack", 32'(cfg_ack_o), 32'(SHADOW));
        chk("load_idle", 32'(idle_ok()), 1);
        ack_cnt = 0;
        enable = 1'b1;

        hs_m = '0; vs_m = '0; de_xm = '0; de_ym = '0;
        de_n = 0; hb_n = 0; vb_n = 0; ls_n = 0; fs_n = 0; fs_i0 = 0;
        xsum = 0; ysum = 0; xbad = 0;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 48; i++) begin
                step();
                if (f == 0) begin
                    if (i < 3) chk("run_x", 32'(raw_x_o), 32'(i));
                    if (!hsync_o) hs_m[raw_x_o[2:0]] = 1'b1;
                    if (!vsync_o) vs_m[raw_y_o[2:0]] = 1'b1;
                    if (de_o) begin
                        de_n++;
                        de_xm[raw_x_o[2:0]] = 1'b1;
                        de_ym[raw_y_o[2:0]] = 1'b1;
                        xsum += int'(x_o);
                        ysum += int'(y_o);
                    end else if (x_o != '0 || y_o != '0) begin
                        xbad++;
                    end
                    hb_n += int'(hblank_o);
                    vb_n += int'(vblank_o);
                    ls_n += int'(line_start_o);
                end
                if (frame_start_o) begin
                    fs_n++;
                    if (i == 0) fs_i0++;
                end
                if (i == 47) chk("fcnt", 32'(frame_cnt_o), 32'(fexp[f]));
            end
        end
        chk("hsync_at_x", 32'(hs_m), 32'h06);
        chk("vsync_at_y", 32'(vs_m), 32'h02);
        chk("de_count", 32'(de_n), 12);
        chk("de_at_x", 32'(de_xm), 32'hF0);
        chk("de_at_y", 32'(de_ym), 32'h38);
        chk("x_sum", 32'(xsum), 18);
        chk("y_sum", 32'(ysum), 12);
        chk("xy_zero_off_de", 32'(xbad), 0);
        chk("hblank_count", 32'(hb_n), 24);
        chk("vblank_count", 32'(vb_n), 24);
        chk("line_starts", 32'(ls_n), 6);
        chk("frame_starts", 32'(fs_n), 5);
        chk("frame_start_pos", 32'(fs_i0), 5);

        // enable gating: drop enable while the counter sits at raw (5,2)
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (raw_x_o == 12'd4 && raw_y_o == 12'd2) found = 1'b1;
        end
        chk("en_find", 32'(found), 1);
        enable = 1'b0;
        bad = 0;
        repeat (10) begin
            step();
            if (!idle_ok()) bad++;
        end
        chk("en_idle", 32'(bad), 0);
        chk("en_fcnt", 32'(frame_cnt_o), 1);
        enable = 1'b1;
        step();
        chk("en_x0", 32'(raw_x_o), 0);
        chk("en_y0", 32'(raw_y_o), 0);
        chk("en_fstart", 32'(frame_start_o), 1);
        step();
        chk("en_x1", 32'(raw_x_o), 1);
        chk("en_fcnt_hold", 32'(frame_cnt_o), 1);

`ifndef CRTC_GEN_SHADOW_EN
        // live shrink: ha 4->2 while the counter is at raw_x=6, row 3
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (raw_x_o == 12'd5 && raw_y_o == 12'd3) found = 1'b1;
        end
        chk("live_find", 32'(found), 1);
        ha = 12'd2; cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        chk("live_x6", 32'(raw_x_o), 6);
        chk("live_x6_x", 32'(x_o), 2);
        step();
        chk("live_wrap", 32'(raw_x_o), 0);
        chk("live_y", 32'(raw_y_o), 4);
        mx = 0; dn = 0;
        repeat (6) begin
            step();
            if (int'(raw_x_o) > mx) mx = int'(raw_x_o);
            dn += int'(de_o);
        end
        chk("live_max_x", 32'(mx), 5);
        chk("live_de", 32'(dn), 2);
        chk("live_next_x", 32'(raw_x_o), 0);
        chk("live_next_y", 32'(raw_y_o), 5);
        chk("live_no_ack", 32'(ack_cnt), 0);
`else
        // shadow update: ha 4->8 requested twice mid-frame, one ack at EOF
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (raw_x_o == 12'd0 && raw_y_o == 12'd2) found = 1'b1;
        end
        chk("sh_find", 32'(found), 1);
        ha = 12'd8; cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        repeat (5) step();
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        ack_cnt = 0; mx = 0; found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (cfg_ack_o) found = 1'b1;
            else if (int'(raw_x_o) > mx) mx = int'(raw_x_o);
        end
        chk("sh_ack", 32'(found), 1);
        chk("sh_old_ht", 32'(mx), 7);
        chk("sh_ack_x", 32'(raw_x_o), 7);
        chk("sh_ack_y", 32'(raw_y_o), 5);
        ack_cnt = 0; mx = 0; dn = 0; found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (raw_y_o == 12'd4) found = 1'b1;
            else if (raw_y_o == 12'd3) begin
                if (int'(raw_x_o) > mx) mx = int'(raw_x_o);
                dn += int'(de_o);
            end
        end
        chk("sh_row_find", 32'(found), 1);
        chk("sh_new_ht", 32'(mx), 11);
        chk("sh_new_de", 32'(dn), 8);
        chk("sh_no_extra_ack", 32'(ack_cnt), 0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
